// File: rtl/mul_share_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_pkg
//   Shared definitions for the Mul-sharing arbiter: default multiplier latency,
//   the requester-index width helper and the tag carried alongside each product.
// -----------------------------------------------------------------------------
package mul_share_pkg;

    // Latency of the Versat Mul unit this block is normally paired with.
    localparam int MUL_LAT_DEFAULT = 4;

    // Tag id field is sized for the largest supported requester count (16).
    localparam int TAG_ID_W = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One tag-pipe stage: a valid bit and the requester that owns the product.
    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. The search starts at the priority pointer and wraps
//   modulo N; after a grant to i the pointer moves to (i+1) mod N. A run pulse
//   reloads the pointer with 0.
// Ports
//   clk, rst   clock, async active-high reset
//   run        reload the priority pointer with 0
//   advance    grants are allowed this cycle
//   req        request vector
//   grant      one-hot or zero, combinational
//   grant_id   index of the granted requester (0 when nothing is granted)
// -----------------------------------------------------------------------------
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          advance,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic          found;
    int            pos;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        pos      = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            idx = IW'(pos);
            if (advance && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (run) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
//   Shares one pipelined Mul unit (fixed latency, no valid/ready) between NREQ
//   requesters. One operand pair is issued per cycle in round-robin order; a
//   tag shift register matched to the Mul latency routes each product back to
//   its requester, 1+MUL_LAT clocks after the handshake.
// Ports
//   clk, rst    clock, async active-high reset
//   run         1-cycle pulse: new accelerator run (clears op_cnt and pointer)
//   running     grants are only given while high
//   req_valid   per-requester operand pair available
//   req_ready   one-hot or zero, requester accepted this cycle
//   req_in0/1   packed operands, requester i at [i*DATA_W +: DATA_W]
//   mul_in0/1   registered operands to Mul
//   mul_out0    product from Mul
//   rsp_valid   one-hot or zero, result for requester i this cycle
//   rsp_data    result, equal to mul_out0
//   busy        an operation sits in the issue register or the tag pipe
//   op_cnt      results delivered since the last run pulse (wraps)
// -----------------------------------------------------------------------------
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   running,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_in0,
    input  logic [NREQ*DATA_W-1:0] req_in1,
    output logic [DATA_W-1:0]      mul_in0,
    output logic [DATA_W-1:0]      mul_in1,
    input  logic [DATA_W-1:0]      mul_out0,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   busy,
    output logic [31:0]            op_cnt
);

    localparam int IW = idw(NREQ);

    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     grant_id;
    logic [DATA_W-1:0] sel_in0;
    logic [DATA_W-1:0] sel_in1;
    tag_t              tag0;
    tag_t              tag_pipe [MUL_LAT];
    tag_t              tag_last;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .advance  (running),
        .req      (req_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // The arbiter only grants valid requesters, so its grant is the handshake.
    assign req_ready = grant;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_in0 = '0;
        sel_in1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_in0 = req_in0[i*DATA_W +: DATA_W];
                sel_in1 = req_in1[i*DATA_W +: DATA_W];
            end
        end
    end

    // Issue stage. Operands hold when idle; Mul ignores them then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_in0 <= '0;
            mul_in1 <= '0;
            tag0    <= '0;
        end else begin
            if (|grant) begin
                mul_in0 <= sel_in0;
                mul_in1 <= sel_in1;
            end
            tag0.vld <= |grant;
            tag0.id  <= TAG_ID_W'(grant_id);
        end
    end

    // Tag pipe. It shifts every cycle because Mul never stalls.
    // NOTE: the tag stages are reset, unlike a plain data delay line, because a
    // reset must discard every in-flight operation rather than let stale valid
    // bits emerge as responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < MUL_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= tag0;
            for (int s = 1; s < MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign tag_last = tag_pipe[MUL_LAT-1];
    assign rsp_data = mul_out0;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_last.vld && (tag_last.id == TAG_ID_W'(i));
        end
    end

    always_comb begin
        busy = tag0.vld;
        for (int s = 0; s < MUL_LAT; s++) busy = busy | tag_pipe[s].vld;
    end

    // A run pulse restarts the count, but a result arriving in the same cycle
    // already belongs to the new run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (run) begin
            op_cnt <= tag_last.vld ? 32'd1 : 32'd0;
        end else if (tag_last.vld) begin
            op_cnt <= op_cnt + 32'd1;
        end
    end

endmodule
